// File: rtl/i2c_master_fsm.sv
// Bit-level I2C master issuing START, addr+W, ACK, mem byte, ACK, data byte, ACK, STOP.
// Define I2C_MASTER_ACK_CHECK_EN to abort to STOP on a NACK and report it on ack_err.
module i2c_master_fsm #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] mem_addr,
  input  logic [7:0] wdata,
  input  logic       sda_i,
  output logic       scl,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK1, MEM, ACK2, DATA, ACK3, STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    mem_q;
  logic [7:0]    data_q;
  logic          tick;

  assign tick = (cnt == CNT_LAST);

`ifdef I2C_MASTER_ACK_CHECK_EN
  logic nack;
  logic is_ack;
  assign is_ack = (state == ACK1) || (state == ACK2) || (state == ACK3);
`else
  logic nack;
  logic unused_sda;
  assign nack       = 1'b0;
  assign unused_sda = sda_i;
  assign ack_err    = 1'b0;
`endif

  // Outputs are registered: at each quarter boundary they are loaded with the
  // value the upcoming quarter needs, so scl/sda_oe never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      q       <= 2'd0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      mem_q   <= 8'h00;
      data_q  <= 8'h00;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
      nack    <= 1'b0;
      ack_err <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking everywhere here, so every branch reads pre-edge state.
      done <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        q   <= 2'd0;
        if (start) begin
          shift  <= {dev_addr, 1'b0};
          mem_q  <= mem_addr;
          data_q <= wdata;
          state  <= START;
          busy   <= 1'b1;
`ifdef I2C_MASTER_ACK_CHECK_EN
          ack_err <= 1'b0;
          nack    <= 1'b0;
`endif
        end
      end else if (!tick) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
        q   <= q + 2'd1;
`ifdef I2C_MASTER_ACK_CHECK_EN
        if (is_ack && q == 2'd2) nack <= sda_i;
`endif
        if (q != 2'd3) begin
          case (state)
            START:   if (q == 2'd1) sda_oe <= 1'b1;
            STOP: begin
              if (q == 2'd0) scl <= 1'b1;
              if (q == 2'd1) sda_oe <= 1'b0;
            end
            default: if (q == 2'd1) scl <= 1'b1;
          endcase
        end else begin
          // Symbol boundary: pick the next symbol and set up its q0 levels.
          scl <= 1'b0;
          case (state)
            START: begin
              state   <= ADDR;
              bit_cnt <= 3'd7;
              sda_oe  <= ~shift[7];
            end
            ADDR, MEM, DATA: begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                case (state)
                  ADDR:    state <= ACK1;
                  MEM:     state <= ACK2;
                  default: state <= ACK3;
                endcase
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
                shift   <= {shift[6:0], 1'b0};
                sda_oe  <= ~shift[6];
              end
            end
            ACK1, ACK2: begin
              if (nack) begin
                state  <= STOP;
                sda_oe <= 1'b1;
`ifdef I2C_MASTER_ACK_CHECK_EN
                ack_err <= 1'b1;
`endif
              end else begin
                state   <= (state == ACK1) ? MEM : DATA;
                shift   <= (state == ACK1) ? mem_q : data_q;
                sda_oe  <= (state == ACK1) ? ~mem_q[7] : ~data_q[7];
                bit_cnt <= 3'd7;
              end
            end
            ACK3: begin
              state  <= STOP;
              sda_oe <= 1'b1;
`ifdef I2C_MASTER_ACK_CHECK_EN
              if (nack) ack_err <= 1'b1;
`endif
            end
            STOP: begin
              state  <= IDLE;
              scl    <= 1'b1;
              sda_oe <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Directed bench for i2c_master_fsm: bus monitor/responder decodes SCL/SDA, checks bytes, ACKs and latency.
// Expectations follow I2C_MASTER_ACK_CHECK_EN when it is defined for the build.
module tb_i2c_master_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start4, start1;
  logic [6:0] dev;
  logic [7:0] mem, wd;
  logic       sda_i4, sda_i1;
  logic       scl4, scl1, oe4, oe1, busy4, busy1, done4, done1, err4, err1;

  i2c_master_fsm #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start4), .dev_addr(dev), .mem_addr(mem),
    .wdata(wd), .sda_i(sda_i4), .scl(scl4), .sda_oe(oe4), .busy(busy4),
    .done(done4), .ack_err(err4)
  );

  i2c_master_fsm #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .dev_addr(dev), .mem_addr(mem),
    .wdata(wd), .sda_i(sda_i1), .scl(scl1), .sda_oe(oe1), .busy(busy1),
    .done(done1), .ack_err(err1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Responder / monitor on whichever DUT is selected.
  logic       sel1, pull, mon_clr, prev_scl, prev_sda;
  logic [2:0] ack_mask;
  logic [7:0] cur;
  logic [7:0] rx_byte [4];
  logic       rx_ack  [4];
  int         nbits, nbytes, nstart, nstop, hi_changes;

  assign sda_i4 = ~oe4 & ~(pull & ~sel1);
  assign sda_i1 = ~oe1 & ~(pull & sel1);

  wire scl_m   = sel1 ? scl1  : scl4;
  wire sda_bus = sel1 ? sda_i1 : sda_i4;
  wire busy_m  = sel1 ? busy1 : busy4;
  wire done_m  = sel1 ? done1 : done4;

  always @(negedge clk) begin
    if (mon_clr) begin
      nbits = 0; nbytes = 0; nstart = 0; nstop = 0; hi_changes = 0;
      pull = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1; cur = 8'h00;
    end else begin
      if (scl_m && prev_scl && (sda_bus !== prev_sda)) begin
        hi_changes++;
        if (!sda_bus) begin nstart++; nbytes = 0; end
        else nstop++;
        nbits = 0;
        pull  = 1'b0;
      end else if (scl_m && !prev_scl) begin
        if (nbits == 8) begin
          if (nbytes < 4) begin rx_byte[nbytes] = cur; rx_ack[nbytes] = sda_bus; end
          nbytes++;
          nbits = 0;
        end else begin
          cur = {cur[6:0], sda_bus};
          nbits++;
        end
      end else if (!scl_m && prev_scl) begin
        pull = (nbits == 8) && (nbytes < 3) ? ack_mask[nbytes] : 1'b0;
      end
      prev_scl = scl_m;
      prev_sda = sda_bus;
    end
  end

  task automatic run_txn(input logic use1, input logic [6:0] d, input logic [7:0] m,
                         input logic [7:0] w, input logic hammer,
                         output int lat, output int ndone);
    sel1 = use1;
    mon_clr = 1'b1;
    repeat (2) @(negedge clk);
    mon_clr = 1'b0;
    dev = d; mem = m; wd = w;
    if (use1) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    check("busy_rise", busy_m, 1);
    lat = -1; ndone = 0;
    for (int i = 1; i <= 2000 && lat < 0; i++) begin
      @(negedge clk);
      if (hammer && i >= 310 && i <= 340) begin
        start4 = (i % 4 == 0);
        dev = ~d; mem = ~m; wd = ~w;
      end else if (hammer) begin
        start4 = 1'b0;
      end
      if (done_m) begin
        lat = i;
        ndone++;
        check("busy_at_done", busy_m, 0);
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
    repeat (20) begin
      @(negedge clk);
      if (done_m) ndone++;
    end
  endtask

  int lat, nd;

  initial begin
    reset = 1'b1; start4 = 1'b0; start1 = 1'b0; sel1 = 1'b0;
    mon_clr = 1'b1; ack_mask = 3'b111;
    dev = 7'h00; mem = 8'h00; wd = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_scl", scl4, 1);
    check("rst_sda_oe", oe4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_ack_err", err4, 0);
    check("rst_scl_div1", scl1, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Fully ACKed write at CLK_DIV=4.
    run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 1'b0, lat, nd);
    check("t1_latency", lat, 464);
    check("t1_done_cnt", nd, 1);
    check("t1_byte0", rx_byte[0], 8'hA0);
    check("t1_ack0", rx_ack[0], 0);
    check("t1_byte1", rx_byte[1], 8'h12);
    check("t1_ack1", rx_ack[1], 0);
    check("t1_byte2", rx_byte[2], 8'hA5);
    check("t1_ack2", rx_ack[2], 0);
    check("t1_nbytes", nbytes, 3);
    check("t1_start_stop", {nstart[7:0], nstop[7:0]}, 16'h0101);
    check("t1_hi_changes", hi_changes, 2);
    check("t1_ack_err", err4, 0);

    // Responder NACKs the address byte.
    ack_mask = 3'b110;
    run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 1'b0, lat, nd);
    check("t2_addr_nack_seen", rx_ack[0], 1);
    check("t2_nstop", nstop, 1);
`ifdef I2C_MASTER_ACK_CHECK_EN
    check("t2_latency", lat, 176);
    check("t2_nbytes", nbytes, 1);
    check("t2_ack_err", err4, 1);
    repeat (10) @(negedge clk);
    check("t2_ack_err_hold", err4, 1);
`else
    check("t2_latency", lat, 464);
    check("t2_nbytes", nbytes, 3);
    check("t2_byte2", rx_byte[2], 8'hA5);
    check("t2_ack_err", err4, 0);
`endif

    // start hammered with new operands during DATA: transaction unaffected.
    ack_mask = 3'b111;
    run_txn(1'b0, 7'h2A, 8'h34, 8'h5C, 1'b1, lat, nd);
    check("t3_latency", lat, 464);
    check("t3_done_cnt", nd, 1);
    check("t3_byte0", rx_byte[0], 8'h54);
    check("t3_byte1", rx_byte[1], 8'h34);
    check("t3_byte2", rx_byte[2], 8'h5C);
    check("t3_ack_err", err4, 0);
    check("t3_idle_after", busy4, 0);

    // Reset during DATA bit 3 (symbol 23 -> cycles 368..383 after busy rise).
    sel1 = 1'b0;
    dev = 7'h11; mem = 8'h22; wd = 8'h33;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (375) @(negedge clk);
    check("t4_busy_before", busy4, 1);
    reset = 1'b1;
    #1;
    check("t4_rst_scl", scl4, 1);
    check("t4_rst_sda_oe", oe4, 0);
    check("t4_rst_busy", busy4, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_txn(1'b0, 7'h3C, 8'hF0, 8'h0F, 1'b0, lat, nd);
    check("t4_latency", lat, 464);
    check("t4_byte0", rx_byte[0], 8'h78);
    check("t4_byte1", rx_byte[1], 8'hF0);
    check("t4_byte2", rx_byte[2], 8'h0F);
    check("t4_done_cnt", nd, 1);

    // CLK_DIV=1 instance.
    run_txn(1'b1, 7'h50, 8'h12, 8'hA5, 1'b0, lat, nd);
    check("t5_latency", lat, 116);
    check("t5_done_cnt", nd, 1);
    check("t5_byte0", rx_byte[0], 8'hA0);
    check("t5_byte1", rx_byte[1], 8'h12);
    check("t5_byte2", rx_byte[2], 8'hA5);
    check("t5_hi_changes", hi_changes, 2);
    check("t5_ack_err", err1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
